// File: rtl/clock_pkg.sv
// Shared encodings and limits for the HH:MM:SS clock controller.
// Mode values, per-field blink bit positions and BCD digit limits.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_t;

  localparam int FLD_SEC = 0;
  localparam int FLD_MIN = 1;
  localparam int FLD_HR  = 2;

  localparam int UNITS_MAX  = 9;
  localparam int TENS_MAX   = 5;
  localparam int MINSEC_MAX = 59;
  localparam int HOUR_MAX   = 23;

  // Binary 0..99 to packed {tens, units} BCD.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [6:0] t;
    logic [6:0] u;
    t = v / 7'd10;
    u = v % 7'd10;
    return {t[3:0], u[3:0]};
  endfunction

endpackage

// File: rtl/bcd_field_cnt.sv
// Two-digit BCD counter wrapping at modulus-1; carry is combinational so a
// caller can ripple several fields within one clock.
module bcd_field_cnt
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic [6:0] modulus,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry
);

  logic [7:0] last;
  logic       at_max;

  assign last   = bin2bcd(modulus - 7'd1);
  assign at_max = ({tens, units} == last);
  assign carry  = inc & ~clr & at_max;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (units == 4'(UNITS_MAX)) begin
        tens  <= tens + 4'd1;
        units <= 4'd0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Run/set controller for the HH:MM:SS chain: ticks ripple carries in RUN,
// btn_inc edits the selected field in SET states; drives digits and blink mask.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int HOURS_MOD = 24,
  parameter bit BLINK_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       blink_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hr_t,
  output logic [3:0] hr_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [1:0] mode,
  output logic [2:0] blink_mask,
  output logic       day_pulse
);

  mode_t      mode_q, mode_d;
  logic       phase_q, phase_d;
  logic [2:0] mask_d;
  logic       run, edit;
  logic       sec_inc, sec_clr, min_inc, hr_inc;
  logic       sec_carry, min_carry, hr_carry;

  // btn_mode takes precedence over any edit in the same cycle.
  assign run     = (mode_q == MODE_RUN);
  assign edit    = btn_inc & ~btn_mode;
  assign sec_inc = run & tick_1hz;
  assign sec_clr = (mode_q == MODE_SET_SEC) & edit;
  assign min_inc = run ? sec_carry : ((mode_q == MODE_SET_MIN) & edit);
  assign hr_inc  = run ? min_carry : ((mode_q == MODE_SET_HR) & edit);

  bcd_field_cnt u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .clr(sec_clr),
    .modulus(7'(MINSEC_MAX + 1)), .tens(sec_t), .units(sec_u), .carry(sec_carry)
  );

  bcd_field_cnt u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0),
    .modulus(7'(MINSEC_MAX + 1)), .tens(min_t), .units(min_u), .carry(min_carry)
  );

  bcd_field_cnt u_hr (
    .clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0),
    .modulus(7'(HOURS_MOD)), .tens(hr_t), .units(hr_u), .carry(hr_carry)
  );

  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    mask_d  = 3'b000;
    if (btn_mode) begin
      phase_d = 1'b0;
      case (mode_q)
        MODE_RUN:     mode_d = MODE_SET_HR;
        MODE_SET_HR:  mode_d = MODE_SET_MIN;
        MODE_SET_MIN: mode_d = MODE_SET_SEC;
        default:      mode_d = MODE_RUN;
      endcase
    end else if (blink_tick && !run) begin
      phase_d = ~phase_q;
    end
    if (BLINK_EN && phase_d) begin
      case (mode_d)
        MODE_SET_HR:  mask_d[FLD_HR]  = 1'b1;
        MODE_SET_MIN: mask_d[FLD_MIN] = 1'b1;
        MODE_SET_SEC: mask_d[FLD_SEC] = 1'b1;
        default:      mask_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q     <= MODE_RUN;
      phase_q    <= 1'b0;
      blink_mask <= 3'b000;
      day_pulse  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      blink_mask <= mask_d;
      day_pulse  <= run & hr_carry;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: seconds-of-day reference model feeds an expected
// queue; a negedge monitor pops and compares every cycle.
module tb_clock_time_ctrl;

  localparam int HM = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_1hz = 1'b0, blink_tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
  logic [1:0] mode;
  logic [2:0] blink_mask;
  logic       day_pulse;

  always #5 clk = ~clk;

  clock_time_ctrl #(.HOURS_MOD(HM), .BLINK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .blink_tick(blink_tick),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u),
    .sec_t(sec_t), .sec_u(sec_u), .mode(mode), .blink_mask(blink_mask),
    .day_pulse(day_pulse)
  );

  typedef struct {
    int hr, mn, sc, md, mask, dp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: time as seconds since midnight, mode 0..3, blink phase.
  int t_s = 0;
  int m_mode = 0;
  int ph = 0;

  task automatic step(input bit r, input bit tk, input bit bt, input bit bm, input bit bi);
    int h, m, s, dp;
    exp_t e;
    @(negedge clk);
    rst = r; tick_1hz = tk; blink_tick = bt; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    dp = 0;
    if (!r) begin
      t_s = 0; m_mode = 0; ph = 0;
    end else begin
      h = t_s / 3600; m = (t_s / 60) % 60; s = t_s % 60;
      case (m_mode)
        0: if (tk) begin
             t_s = t_s + 1;
             if (t_s == HM * 3600) begin t_s = 0; dp = 1; end
           end
        1: if (bi && !bm) t_s = ((h + 1) % HM) * 3600 + m * 60 + s;
        2: if (bi && !bm) t_s = h * 3600 + ((m + 1) % 60) * 60 + s;
        default: if (bi && !bm) t_s = h * 3600 + m * 60;
      endcase
      if (bm) begin
        m_mode = (m_mode + 1) % 4; ph = 0;
      end else if (bt && m_mode != 0) begin
        ph = 1 - ph;
      end
    end
    e.hr = t_s / 3600; e.mn = (t_s / 60) % 60; e.sc = t_s % 60;
    e.md = m_mode; e.dp = dp;
    e.mask = (ph == 1 && m_mode != 0) ? (1 << (3 - m_mode)) : 0;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input int exp);
    checks++;
    if (act !== 8'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bcd(input string name, input logic [3:0] d, input int lim);
    checks++;
    if ($isunknown(d) || int'(d) > lim) begin
      errors++;
      $display("FAIL %s: digit %0d exceeds limit %0d", name, d, lim);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hr_t", 8'(hr_t), e.hr / 10);
      chk("hr_u", 8'(hr_u), e.hr % 10);
      chk("min_t", 8'(min_t), e.mn / 10);
      chk("min_u", 8'(min_u), e.mn % 10);
      chk("sec_t", 8'(sec_t), e.sc / 10);
      chk("sec_u", 8'(sec_u), e.sc % 10);
      chk("mode", 8'(mode), e.md);
      chk("blink_mask", 8'(blink_mask), e.mask);
      chk("day_pulse", 8'(day_pulse), e.dp);
      chk_bcd("hr_t_range", hr_t, 2);
      chk_bcd("min_t_range", min_t, 5);
      chk_bcd("sec_u_range", sec_u, 9);
    end
  end

  initial begin
    repeat (2) step(0, 0, 0, 0, 0);
    // Run from midnight: 61 ticks.
    repeat (61) step(1, 1, 0, 0, 0);
    // Preload 23:59:00 with ticks offered during setting, then run to rollover.
    step(1, 0, 0, 1, 0);
    repeat (23) step(1, 1, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    repeat (58) step(1, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    repeat (60) step(1, 1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0);
    // SET_HR: 25 increments wrap hours 0 -> 1.
    step(1, 0, 0, 1, 0);
    repeat (25) step(1, 1, 0, 0, 1);
    // SET_MIN: wrap 59 -> 00 with no carry into hours.
    step(1, 0, 0, 1, 0);
    repeat (60) step(1, 0, 0, 0, 1);
    // SET_SEC clear then back to RUN.
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    repeat (37) step(1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    // btn_mode with btn_inc in SET_HR; tick with btn_mode in SET_SEC and RUN.
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    // Blink in SET_MIN, then reset mid-setting.
    repeat (3) step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Randomized traffic.
    repeat (4000) begin
      step($urandom_range(0, 399) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 2) == 0);
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 8'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
